// File: rtl/decode_stage_pipelined_if.sv
// Bus bundle for the LEGv8 decode stage: the IF-side instruction handshake,
// control-unit signals, the write-back port and the ID/EX outputs.
interface decode_stage_pipelined_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int CW   = 10
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            ctrl_reg2loc;
    logic [1:0]      ctrl_imm_sel;
    logic            ctrl_use_rn;
    logic            ctrl_use_rm;
    logic            ctrl_mem_read;
    logic [CW-1:0]   ctrl_bundle;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_ready;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;
    logic [XLEN-1:0] ex_imm;
    logic [AW-1:0]   ex_rn;
    logic [AW-1:0]   ex_rm;
    logic [AW-1:0]   ex_rd;
    logic            ex_mem_read;
    logic [CW-1:0]   ex_ctrl;

    // The decode stage itself
    modport slave (
        input  if_valid, if_instr, if_pc,
        output id_ready,
        input  ctrl_reg2loc, ctrl_imm_sel, ctrl_use_rn, ctrl_use_rm,
        input  ctrl_mem_read, ctrl_bundle,
        input  wb_we, wb_addr, wb_data,
        input  ex_ready, flush,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
        output ex_rn, ex_rm, ex_rd, ex_mem_read, ex_ctrl
    );

    // The surrounding pipeline (fetch, control, write-back, execute)
    modport master (
        output if_valid, if_instr, if_pc,
        input  id_ready,
        output ctrl_reg2loc, ctrl_imm_sel, ctrl_use_rn, ctrl_use_rm,
        output ctrl_mem_read, ctrl_bundle,
        output wb_we, wb_addr, wb_data,
        output ex_ready, flush,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
        input  ex_rn, ex_rm, ex_rd, ex_mem_read, ex_ctrl
    );
endinterface

// File: rtl/decode_stage_pipelined.sv
// LEGv8 instruction-decode stage: register file with hard-zero register,
// write-back bypass, Reg2Loc operand select, immediate extension, load-use
// hazard detection and the ID/EX pipeline register with valid/ready flow.
module decode_stage_pipelined #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31,
    parameter int CW       = 10
) (
    input  logic clk,
    input  logic rst_n,
    decode_stage_pipelined_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rn_addr;
    logic [AW-1:0]   rm_addr;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;
    logic [XLEN-1:0] imm_val;
    logic            hazard;
    logic            load_en;

    assign rn_addr = AW'(bus.if_instr[9:5]);
    assign rd_addr = AW'(bus.if_instr[4:0]);
    // Reg2Loc: stores/CBZ name their second operand in the Rt field
    assign rm_addr = bus.ctrl_reg2loc ? AW'(bus.if_instr[4:0]) : AW'(bus.if_instr[20:16]);

    // Register file write port; the zero register is never written so it stays 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && (bus.wb_addr != ZERO_ADDR)) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Operand reads: zero register first, then same-cycle write-back bypass
    always_comb begin
        rd1_val = regs[rn_addr];
        if (rn_addr == ZERO_ADDR) begin
            rd1_val = '0;
        end else if (bus.wb_we && (bus.wb_addr == rn_addr)) begin
            rd1_val = bus.wb_data;
        end
        rd2_val = regs[rm_addr];
        if (rm_addr == ZERO_ADDR) begin
            rd2_val = '0;
        end else if (bus.wb_we && (bus.wb_addr == rm_addr)) begin
            rd2_val = bus.wb_data;
        end
    end

    // Immediate extraction; I-format is unsigned, the others sign-extend.
    // The <<2 for branch offsets is left to EX.
    always_comb begin
        imm_val = '0;
        unique case (bus.ctrl_imm_sel)
            2'b00:   imm_val = {{(XLEN-9){bus.if_instr[20]}},  bus.if_instr[20:12]};
            2'b01:   imm_val = {{(XLEN-12){1'b0}},             bus.if_instr[21:10]};
            2'b10:   imm_val = {{(XLEN-19){bus.if_instr[23]}}, bus.if_instr[23:5]};
            default: imm_val = {{(XLEN-26){bus.if_instr[25]}}, bus.if_instr[25:0]};
        endcase
    end

    // Load-use hazard and handshake; deliberately independent of wb_*
    always_comb begin
        hazard = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != ZERO_ADDR) && bus.if_valid &&
                 ((bus.ctrl_use_rn && (rn_addr == bus.ex_rd)) ||
                  (bus.ctrl_use_rm && (rm_addr == bus.ex_rd)));
        load_en      = bus.ex_ready || !bus.ex_valid;
        bus.id_ready = load_en && !hazard;
    end

    // ID/EX register: flush beats stall, stall holds, hazard inserts a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= '0;
            bus.ex_rd1      <= '0;
            bus.ex_rd2      <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rn       <= '0;
            bus.ex_rm       <= '0;
            bus.ex_rd       <= '0;
            bus.ex_mem_read <= 1'b0;
            bus.ex_ctrl     <= '0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
        end else if (!load_en) begin
            bus.ex_valid <= bus.ex_valid;
        end else if (hazard) begin
            bus.ex_valid <= 1'b0;
        end else begin
            bus.ex_valid    <= bus.if_valid;
            bus.ex_pc       <= bus.if_pc;
            bus.ex_rd1      <= rd1_val;
            bus.ex_rd2      <= rd2_val;
            bus.ex_imm      <= imm_val;
            bus.ex_rn       <= rn_addr;
            bus.ex_rm       <= rm_addr;
            bus.ex_rd       <= rd_addr;
            bus.ex_mem_read <= bus.ctrl_mem_read;
            bus.ex_ctrl     <= bus.ctrl_bundle;
        end
    end
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_decode_stage_pipelined;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int CW   = 10;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    decode_stage_pipelined_if #(.XLEN(XLEN), .AW(AW), .CW(CW)) bus ();

    decode_stage_pipelined #(.XLEN(XLEN), .NREGS(32), .ZERO_REG(31), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: architectural registers and the ID/EX contents
    logic [63:0] m_regs [32];
    logic        m_valid;
    logic        m_mem;
    logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rn, m_rm, m_rd;
    logic [9:0]  m_ctrl;
    logic        seen_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [63:0] m_immediate(input logic [31:0] ins, input logic [1:0] sel);
        logic signed [63:0] v;
        case (sel)
            2'b00:   v = 64'($signed(ins[20:12]));
            2'b01:   v = 64'(ins[21:10]);
            2'b10:   v = 64'($signed(ins[23:5]));
            default: v = 64'($signed(ins[25:0]));
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_valid = 0; m_mem = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rn = 0; m_rm = 0; m_rd = 0; m_ctrl = 0;
    endtask

    task automatic idle();
        bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0;
        bus.ctrl_reg2loc = 0; bus.ctrl_imm_sel = 0; bus.ctrl_use_rn = 0;
        bus.ctrl_use_rm = 0; bus.ctrl_mem_read = 0; bus.ctrl_bundle = 0;
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.ex_ready = 1; bus.flush = 0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc, input logic r2l,
                         input logic [1:0] isel, input logic urn, input logic urm, input logic mr);
        bus.if_valid = 1; bus.if_instr = ins; bus.if_pc = pc;
        bus.ctrl_reg2loc = r2l; bus.ctrl_imm_sel = isel; bus.ctrl_use_rn = urn;
        bus.ctrl_use_rm = urm; bus.ctrl_mem_read = mr; bus.ctrl_bundle = 10'(pc);
    endtask

    // One clock: check id_ready, advance the model across the edge, compare ID/EX
    task automatic do_cycle();
        logic [4:0]  rn, rm;
        logic        hz, load_en, accept;
        logic [63:0] n_rd1, n_rd2;
        #1;
        rn = bus.if_instr[9:5];
        rm = bus.ctrl_reg2loc ? bus.if_instr[4:0] : bus.if_instr[20:16];
        hz = m_valid && m_mem && (m_rd != 5'd31) && bus.if_valid &&
             ((bus.ctrl_use_rn && rn == m_rd) || (bus.ctrl_use_rm && rm == m_rd));
        load_en = bus.ex_ready || !m_valid;
        seen_ready = bus.id_ready;
        chk("id_ready", 64'(bus.id_ready), 64'(load_en && !hz));
        n_rd1 = m_read(rn);
        n_rd2 = m_read(rm);
        accept = !bus.flush && load_en && !hz;
        @(posedge clk);
        if (bus.flush || (load_en && hz)) begin
            m_valid = 0;
        end else if (accept) begin
            m_valid = bus.if_valid; m_pc = bus.if_pc; m_rd1 = n_rd1; m_rd2 = n_rd2;
            m_imm = m_immediate(bus.if_instr, bus.ctrl_imm_sel);
            m_rn = rn; m_rm = rm; m_rd = bus.if_instr[4:0];
            m_mem = bus.ctrl_mem_read; m_ctrl = bus.ctrl_bundle;
        end
        if (bus.wb_we && bus.wb_addr != 5'd31) m_regs[bus.wb_addr] = bus.wb_data;
        #1;
        chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        if (m_valid) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_rd1", bus.ex_rd1, m_rd1);
            chk("ex_rd2", bus.ex_rd2, m_rd2);
            chk("ex_imm", bus.ex_imm, m_imm);
            chk("ex_rn", 64'(bus.ex_rn), 64'(m_rn));
            chk("ex_rm", 64'(bus.ex_rm), 64'(m_rm));
            chk("ex_rd", 64'(bus.ex_rd), 64'(m_rd));
            chk("ex_mem_read", 64'(bus.ex_mem_read), 64'(m_mem));
            chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
        end
        $display("txn t=%0t in_v=%0b id_ready=%0b ex_v=%0b pc=%h rd1=%h rd2=%h imm=%h",
                 $time, bus.if_valid, seen_ready, bus.ex_valid, bus.ex_pc, bus.ex_rd1, bus.ex_rd2, bus.ex_imm);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'h458, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] ins;
        n_cmp = 0; n_err = 0;
        idle();
        model_reset();
        rst_n = 0;
        #2;
        chk("reset ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("reset ex_pc", bus.ex_pc, 64'd0);
        chk("reset ex_rd1", bus.ex_rd1, 64'd0);
        chk("reset ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("reset id_ready", 64'(bus.id_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1;

        // Write-then-read same cycle: ADD X1,X5,X5 with X5 being written
        issue(rtype(5'd1, 5'd5, 5'd5), 64'h10, 0, 2'b00, 1, 1, 0);
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 64'hDEAD;
        do_cycle();
        chk("bypass rd1", bus.ex_rd1, 64'hDEAD);
        chk("bypass rd2", bus.ex_rd2, 64'hDEAD);
        bus.wb_we = 0;
        issue(rtype(5'd1, 5'd5, 5'd0), 64'h14, 0, 2'b00, 1, 1, 0);
        do_cycle();
        chk("array keeps X5", bus.ex_rd1, 64'hDEAD);

        // Zero register: write to X31 is ignored, reads give zero
        issue(rtype(5'd1, 5'd31, 5'd31), 64'h18, 0, 2'b00, 1, 1, 0);
        bus.wb_we = 1; bus.wb_addr = 5'd31; bus.wb_data = 64'h1234;
        do_cycle();
        chk("xzr bypass", bus.ex_rd1, 64'd0);
        bus.wb_we = 0;
        do_cycle();
        chk("xzr read", bus.ex_rd1, 64'd0);

        // Immediate formats
        issue({11'h7C2, 9'h1F8, 2'b00, 5'd3, 5'd2}, 64'h20, 0, 2'b00, 1, 0, 0);
        do_cycle();
        chk("imm D -8", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        issue({10'h244, 12'hFFF, 5'd3, 5'd2}, 64'h24, 0, 2'b01, 1, 0, 0);
        do_cycle();
        chk("imm I 0xFFF", bus.ex_imm, 64'h0000_0000_0000_0FFF);
        issue({8'hB4, 19'h7FFFF, 5'd2}, 64'h28, 1, 2'b10, 0, 1, 0);
        do_cycle();
        chk("imm CB -1", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        // Load-use via Rn: LDUR X2,[X3] then ADD X4,X2,X1
        issue({11'h7C2, 9'h0, 2'b00, 5'd3, 5'd2}, 64'h30, 0, 2'b00, 1, 0, 1);
        do_cycle();
        issue(rtype(5'd4, 5'd2, 5'd1), 64'h34, 0, 2'b00, 1, 1, 0);
        do_cycle();
        chk("lu stall ready", 64'(seen_ready), 64'd0);
        chk("lu bubble", 64'(bus.ex_valid), 64'd0);
        do_cycle();
        chk("lu issue ready", 64'(seen_ready), 64'd1);
        chk("lu issue pc", bus.ex_pc, 64'h34);
        chk("lu issue rn", 64'(bus.ex_rn), 64'd2);
        chk("lu issue rd", 64'(bus.ex_rd), 64'd4);

        // Load-use via Reg2Loc Rm: LDUR X2 then STUR X2,[X5]
        issue({11'h7C2, 9'h0, 2'b00, 5'd3, 5'd2}, 64'h38, 0, 2'b00, 1, 0, 1);
        do_cycle();
        issue({11'h7C0, 9'h0, 2'b00, 5'd5, 5'd2}, 64'h3C, 1, 2'b00, 1, 1, 0);
        do_cycle();
        chk("st stall ready", 64'(seen_ready), 64'd0);
        chk("st bubble", 64'(bus.ex_valid), 64'd0);
        do_cycle();
        chk("st issue pc", bus.ex_pc, 64'h3C);
        chk("st issue rm", 64'(bus.ex_rm), 64'd2);

        // Back-pressure: three stalled cycles then release
        issue(rtype(5'd6, 5'd1, 5'd0), 64'h100, 0, 2'b00, 1, 1, 0);
        do_cycle();
        issue(rtype(5'd7, 5'd1, 5'd0), 64'h200, 0, 2'b00, 1, 1, 0);
        bus.ex_ready = 0;
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("bp ready", 64'(seen_ready), 64'd0);
            chk("bp hold pc", bus.ex_pc, 64'h100);
        end
        bus.ex_ready = 1;
        do_cycle();
        chk("bp release pc", bus.ex_pc, 64'h200);

        // Flush with a live ID/EX and a valid IF instruction
        issue(rtype(5'd8, 5'd1, 5'd0), 64'h300, 0, 2'b00, 1, 1, 0);
        bus.flush = 1;
        do_cycle();
        chk("flush ex_valid", 64'(bus.ex_valid), 64'd0);
        bus.flush = 0;
        idle();
        do_cycle();
        chk("post flush ready", 64'(seen_ready), 64'd1);

        // Reset asserted in the middle of a stall
        issue(rtype(5'd9, 5'd5, 5'd5), 64'h400, 0, 2'b00, 1, 1, 1);
        do_cycle();
        bus.ex_ready = 0;
        do_cycle();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("midrst ex_pc", bus.ex_pc, 64'd0);
        chk("midrst ex_rd1", bus.ex_rd1, 64'd0);
        chk("midrst ex_mem", 64'(bus.ex_mem_read), 64'd0);
        chk("midrst ex_rd", 64'(bus.ex_rd), 64'd0);
        @(negedge clk);
        rst_n = 1;
        idle();
        issue(rtype(5'd1, 5'd5, 5'd0), 64'h500, 0, 2'b00, 1, 1, 0);
        do_cycle();
        chk("regs cleared", bus.ex_rd1, 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            ins = $urandom;
            ins[9:5] = rand_reg();
            ins[20:16] = rand_reg();
            ins[4:0] = rand_reg();
            bus.if_valid = ($urandom_range(0, 3) != 0);
            bus.if_instr = ins;
            bus.if_pc = {$urandom, $urandom};
            bus.ctrl_reg2loc = 1'($urandom);
            bus.ctrl_imm_sel = 2'($urandom);
            bus.ctrl_use_rn = 1'($urandom);
            bus.ctrl_use_rm = 1'($urandom);
            bus.ctrl_mem_read = ($urandom_range(0, 2) == 0);
            bus.ctrl_bundle = 10'($urandom);
            bus.wb_we = 1'($urandom);
            bus.wb_addr = rand_reg();
            bus.wb_data = {$urandom, $urandom};
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
